// File: rtl/tge_pkt_sched_if.sv
// ============================================================================
//  tge_pkt_sched_if : channel-side and 10GbE-side signals of the packet
//  scheduler, grouped for connection between the scheduler and its neighbours.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface tge_pkt_sched_if;
  logic        i_req0;
  logic        i_req1;
  logic [63:0] i_data0;
  logic [63:0] i_data1;
  logic        i_valid0;
  logic        i_valid1;
  logic        o_ready0;
  logic        o_ready1;
  logic        tx_afull;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_eof;
  logic [31:0] o_pkt_cnt0;
  logic [31:0] o_pkt_cnt1;
  logic        o_busy;

  modport master (
    input  i_req0, i_req1, i_data0, i_data1, i_valid0, i_valid1, tx_afull,
    output o_ready0, o_ready1, tx_data, tx_valid, tx_eof,
           o_pkt_cnt0, o_pkt_cnt1, o_busy
  );

  modport slave (
    output i_req0, i_req1, i_data0, i_data1, i_valid0, i_valid1, tx_afull,
    input  o_ready0, o_ready1, tx_data, tx_valid, tx_eof,
           o_pkt_cnt0, o_pkt_cnt1, o_busy
  );
endinterface

`default_nettype wire

// File: rtl/tge_pkt_sched.sv
// ============================================================================
//  tge_pkt_sched : per-packet round-robin scheduler merging two serialized
//  64-bit channels onto one 10GbE transmit port (header + payload + gap).
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tge_pkt_sched #(
  parameter int PAYLOAD_WORDS = 128,
  parameter int GAP_CYCLES    = 16,
  parameter int SEQ_WIDTH     = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  tge_pkt_sched_if.master bus
);

  localparam int WCW = $clog2(PAYLOAD_WORDS);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t               state_q,      state_d;
  logic                 grant_q,      grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [SEQ_WIDTH-1:0] seq_q,        seq_d;
  logic [WCW-1:0]       wcnt_q,       wcnt_d;
  logic [GCW-1:0]       gcnt_q,       gcnt_d;
  logic [63:0]          tx_data_q,    tx_data_d;
  logic                 tx_valid_q,   tx_valid_d;
  logic                 tx_eof_q,     tx_eof_d;
  logic [31:0]          pkt_cnt0_q,   pkt_cnt0_d;
  logic [31:0]          pkt_cnt1_q,   pkt_cnt1_d;

  logic        w_valid_g;
  logic [63:0] w_data_g;

  assign w_valid_g = grant_q ? bus.i_valid1 : bus.i_valid0;
  assign w_data_g  = grant_q ? bus.i_data1  : bus.i_data0;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    seq_d        = seq_q;
    wcnt_d       = wcnt_q;
    gcnt_d       = gcnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    tx_eof_d     = 1'b0;
    pkt_cnt0_d   = pkt_cnt0_q;
    pkt_cnt1_d   = pkt_cnt1_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.tx_afull && (bus.i_req0 || bus.i_req1)) begin
          // A tie goes to the channel that did not win last time.
          if (bus.i_req0 && bus.i_req1) grant_d = ~last_grant_q;
          else                          grant_d = bus.i_req1;
          last_grant_d = grant_d;
          state_d      = S_HEADER;
        end
      end
      S_HEADER: begin
        tx_data_d  = {7'd0, grant_q, 56'(seq_q)};
        tx_valid_d = 1'b1;
        seq_d      = seq_q + SEQ_WIDTH'(1);
        wcnt_d     = '0;
        state_d    = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (w_valid_g) begin
          tx_data_d  = w_data_g;
          tx_valid_d = 1'b1;
          wcnt_d     = wcnt_q + WCW'(1);
          if (wcnt_q == WCW'(PAYLOAD_WORDS - 1)) begin
            tx_eof_d = 1'b1;
            if (grant_q) pkt_cnt1_d = pkt_cnt1_q + 32'd1;
            else         pkt_cnt0_d = pkt_cnt0_q + 32'd1;
            gcnt_d  = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gcnt_d = gcnt_q + GCW'(1);
        if (gcnt_q == GCW'(GAP_CYCLES - 1)) begin
          gcnt_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      seq_q        <= '0;
      wcnt_q       <= '0;
      gcnt_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_eof_q     <= 1'b0;
      pkt_cnt0_q   <= '0;
      pkt_cnt1_q   <= '0;
    end else if (ce) begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seq_q        <= seq_d;
      wcnt_q       <= wcnt_d;
      gcnt_q       <= gcnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_eof_q     <= tx_eof_d;
      pkt_cnt0_q   <= pkt_cnt0_d;
      pkt_cnt1_q   <= pkt_cnt1_d;
    end
  end

  // The held word reappears once ce returns, so it is masked while stalled.
  assign bus.tx_valid   = tx_valid_q & ce;
  assign bus.tx_eof     = tx_eof_q & ce;
  assign bus.tx_data    = tx_data_q;
  assign bus.o_ready0   = ce && (state_q == S_PAYLOAD) && !grant_q;
  assign bus.o_ready1   = ce && (state_q == S_PAYLOAD) &&  grant_q;
  assign bus.o_pkt_cnt0 = pkt_cnt0_q;
  assign bus.o_pkt_cnt1 = pkt_cnt1_q;
  assign bus.o_busy     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_tge_pkt_sched.sv
// ============================================================================
//  tb_tge_pkt_sched : scoreboard bench for tge_pkt_sched with PAYLOAD_WORDS=4,
//  GAP_CYCLES=2, SEQ_WIDTH=4.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tge_pkt_sched;
  localparam int PW  = 4;
  localparam int GAP = 2;
  localparam int SW  = 4;

  typedef struct packed {
    logic [63:0] data;
    logic        eof;
    logic        hdr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  exp_t        exp_q[$];
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  int          hdr_cyc[$];
  int          eof_cyc  = 0;
  int          cyc      = 0;
  int          n_chk    = 0;
  int          n_fail   = 0;
  int          rdy_viol = 0;
  logic        cur_ch   = 1'b0;
  logic        bubble0  = 1'b0;
  logic        tog      = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tge_pkt_sched_if bif();

  tge_pkt_sched #(
    .PAYLOAD_WORDS(PW),
    .GAP_CYCLES   (GAP),
    .SEQ_WIDTH    (SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .bus(bif)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  // Queue one packet: expected header/payload on tx, payload words into the channel source.
  task automatic send_pkt(input logic ch, input int seq, input logic [63:0] base);
    exp_t          e;
    logic [SW-1:0] s;
    s      = SW'(seq);
    e.data = {7'd0, ch, 56'(s)};
    e.eof  = 1'b0;
    e.hdr  = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < PW; i++) begin
      e.data = base + 64'(i + 1);
      e.eof  = (i == PW - 1);
      e.hdr  = 1'b0;
      exp_q.push_back(e);
      if (ch) q1.push_back(e.data);
      else    q0.push_back(e.data);
    end
  endtask

  task automatic wait_cnt(input int c0, input int c1, input string nm);
    int t = 0;
    while (!(bif.o_pkt_cnt0 == 32'(c0) && bif.o_pkt_cnt1 == 32'(c1)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_pkt_cnt0"}, 64'(bif.o_pkt_cnt0), 64'(c0));
    check({nm, "_pkt_cnt1"}, 64'(bif.o_pkt_cnt1), 64'(c1));
  endtask

  task automatic wait_word(input logic [63:0] w, input string nm);
    int t = 0;
    while (!(bif.tx_valid && bif.tx_data == w) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({nm, "_seen"}, 64'(bif.tx_valid && bif.tx_data == w), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Channel sources: present the head word, drop it once the DUT has taken it.
  initial begin
    logic f0, f1;
    bif.i_valid0 = 1'b0;
    bif.i_valid1 = 1'b0;
    bif.i_data0  = '0;
    bif.i_data1  = '0;
    forever begin
      @(negedge clk);
      f0 = bif.i_valid0 && bif.o_ready0;
      f1 = bif.i_valid1 && bif.o_ready1;
      @(posedge clk);
      if (f0 && !rst && ce && q0.size() > 0) void'(q0.pop_front());
      if (f1 && !rst && ce && q1.size() > 0) void'(q1.pop_front());
      #1;
      tog          = ~tog;
      bif.i_valid0 = (q0.size() > 0) && (!bubble0 || tog);
      bif.i_data0  = (q0.size() > 0) ? q0[0] : 64'd0;
      bif.i_valid1 = (q1.size() > 0);
      bif.i_data1  = (q1.size() > 0) ? q1[0] : 64'd0;
    end
  end

  // Monitor: every valid tx word is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bif.tx_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_word: actual=%h required=none", bif.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", bif.tx_data, e.data);
          check("tx_eof", 64'(bif.tx_eof), 64'(e.eof));
          if (e.hdr) begin
            hdr_cyc.push_back(cyc);
            cur_ch = bif.tx_data[56];
          end
          if (e.eof) eof_cyc = cyc;
        end
      end else if (bif.tx_eof) begin
        n_chk++;
        n_fail++;
        $display("FAIL eof_without_valid: actual=1 required=0");
      end
      if (bif.o_busy && ((!cur_ch && bif.o_ready1) || (cur_ch && bif.o_ready0)))
        rdy_viol++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n0, t;
    bif.i_req0   = 1'b0;
    bif.i_req1   = 1'b0;
    bif.tx_afull = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_data",  bif.tx_data, 64'd0);
    check("rst_tx_valid", 64'(bif.tx_valid), 64'd0);
    check("rst_tx_eof",   64'(bif.tx_eof), 64'd0);
    check("rst_ready0",   64'(bif.o_ready0), 64'd0);
    check("rst_ready1",   64'(bif.o_ready1), 64'd0);
    check("rst_busy",     64'(bif.o_busy), 64'd0);
    check("rst_pkt_cnt0", 64'(bif.o_pkt_cnt0), 64'd0);
    check("rst_pkt_cnt1", 64'(bif.o_pkt_cnt1), 64'd0);
    rst = 1'b0;

    // Single channel, with a two-cycle clock-enable stall mid-payload
    send_pkt(1'b0, 0, 64'h0);
    bif.i_req0 = 1'b1;
    wait_word(64'd2, "t1_w2");
    @(posedge clk);
    #1 ce = 1'b0;
    @(negedge clk);
    check("ce_ready0", 64'(bif.o_ready0), 64'd0);
    check("ce_valid",  64'(bif.tx_valid), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 ce = 1'b1;
    wait_cnt(1, 0, "t1");
    bif.i_req0 = 1'b0;

    // Bubbles on channel 0; header carries seq 1
    bubble0 = 1'b1;
    send_pkt(1'b0, 1, 64'h20);
    bif.i_req0 = 1'b1;
    wait_cnt(2, 0, "t3");
    bif.i_req0 = 1'b0;
    bubble0    = 1'b0;
    @(negedge clk);
    n = eof_cyc - hdr_cyc[$];
    check("t3_bubble_span", 64'(n == 7 || n == 8), 64'd1);

    // Almost-full blocks a pending start, not a running packet
    bif.tx_afull = 1'b1;
    bif.i_req1   = 1'b1;
    repeat (6) @(negedge clk);
    check("afull_hold_busy", 64'(bif.o_busy), 64'd0);
    send_pkt(1'b1, 2, 64'h40);
    n0 = hdr_cyc.size();
    @(posedge clk);
    #1 bif.tx_afull = 1'b0;
    n = cyc;
    t = 0;
    while (hdr_cyc.size() == n0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("afull_release_latency", 64'(hdr_cyc[$] - n), 64'd2);
    wait_word(64'h41, "t4_w1");
    bif.tx_afull = 1'b1;
    wait_cnt(2, 1, "t4");
    repeat (5) @(negedge clk);
    check("afull_block_busy", 64'(bif.o_busy), 64'd0);
    bif.i_req1   = 1'b0;
    bif.tx_afull = 1'b0;

    // Both held from reset: ch0, ch1, ch0 with seq 0,1,2, minimum period
    do_reset();
    hdr_cyc.delete();
    send_pkt(1'b0, 0, 64'h100);
    send_pkt(1'b1, 1, 64'h200);
    send_pkt(1'b0, 2, 64'h300);
    bif.i_req0 = 1'b1;
    bif.i_req1 = 1'b1;
    wait_cnt(2, 1, "t2");
    bif.i_req0 = 1'b0;
    bif.i_req1 = 1'b0;
    @(negedge clk);
    check("t2_period_a", 64'(hdr_cyc[1] - hdr_cyc[0]), 64'(2 + PW + GAP));
    check("t2_period_b", 64'(hdr_cyc[2] - hdr_cyc[1]), 64'(2 + PW + GAP));

    // Reset on payload word 2 truncates the packet; next tie restarts at ch0, seq 0
    send_pkt(1'b0, 3, 64'h50);
    bif.i_req0 = 1'b1;
    wait_word(64'h52, "t5_w2");
    rst        = 1'b1;
    bif.i_req0 = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx_data",  bif.tx_data, 64'd0);
    check("mid_rst_tx_valid", 64'(bif.tx_valid), 64'd0);
    check("mid_rst_tx_eof",   64'(bif.tx_eof), 64'd0);
    check("mid_rst_ready0",   64'(bif.o_ready0), 64'd0);
    check("mid_rst_busy",     64'(bif.o_busy), 64'd0);
    check("mid_rst_pkt_cnt0", 64'(bif.o_pkt_cnt0), 64'd0);
    rst = 1'b0;
    exp_q.delete();
    q0.delete();
    send_pkt(1'b0, 0, 64'h600);
    send_pkt(1'b1, 1, 64'h700);
    bif.i_req0 = 1'b1;
    bif.i_req1 = 1'b1;
    wait_cnt(1, 1, "t5");
    bif.i_req0 = 1'b0;
    bif.i_req1 = 1'b0;

    // 17 packets: sequence number runs to 15 and wraps to 0
    do_reset();
    for (int k = 0; k < 17; k++)
      send_pkt(k[0], k, 64'h1000 + 64'(k * 16));
    bif.i_req0 = 1'b1;
    bif.i_req1 = 1'b1;
    wait_cnt(9, 8, "t6");
    bif.i_req0 = 1'b0;
    bif.i_req1 = 1'b0;
    check("t6_pkt_total", 64'(bif.o_pkt_cnt0 + bif.o_pkt_cnt1), 64'd17);

    repeat (6) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("ready_isolation",    64'(rdy_viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tge_pkt_sched.md
# tge_pkt_sched

Packet scheduler that shares one 10GbE transmit port between two 64-bit serialized word streams, each produced by a DRAM-readout parallel-to-serial stage. It arbitrates per packet, round-robin between the two channels. Each packet it emits is one header word carrying the channel ID and a global sequence number, followed by exactly PAYLOAD_WORDS payload words, with end-of-frame on the last word. An enforced inter-packet gap follows each packet. It sits between the per-channel serializers and the 10GbE core transmit interface.

## Interface
- PAYLOAD_WORDS, 128: payload words per packet; power of two, minimum 2.
- GAP_CYCLES, 16: idle cycles after each end-of-frame; minimum 1.
- SEQ_WIDTH, 48: width of the sequence number; maximum 56.
- clk  in  1  system clock; only clock.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when low, every register holds its value.
- i_req0, i_req1  in  1  channel n has at least PAYLOAD_WORDS words buffered. Level signal, sampled only in IDLE.
- i_data0, i_data1  in  64  channel n word.
- i_valid0, i_valid1  in  1  channel n word valid.
- o_ready0, o_ready1  out  1  channel n word accepted when valid and ready are both high in the same cycle.
- tx_afull  in  1  10GbE core almost-full. Blocks new packet starts only.
- tx_data  out  64  word to the core.
- tx_valid  out  1  tx_data valid.
- tx_eof  out  1  last word of packet; only ever high together with tx_valid.
- o_pkt_cnt0, o_pkt_cnt1  out  32  packets completed per channel; wraps modulo 2^32.
- o_busy  out  1  state is not IDLE.

## Operation
- States: IDLE, HEADER, PAYLOAD, GAP.
- IDLE:
  - If tx_afull=0 and any i_req is high, latch the grant g and go to HEADER. Otherwise stay.
  - If both requests are high, g = ~last_grant. If only one is high, g = that channel.
  - last_grant <= g at grant time.
- HEADER: one cycle. Register tx_data = {7'b0, g, (56-SEQ_WIDTH)'b0, seq}, tx_valid=1, tx_eof=0. Then seq <= seq+1, wrapping modulo 2^SEQ_WIDTH. Go to PAYLOAD with word counter = 0.
- PAYLOAD:
  - o_ready_g = 1; o_ready of the other channel = 0.
  - On each accept: tx_data <= i_data_g, tx_valid <= 1, counter increments.
  - If i_valid_g = 0: tx_valid <= 0 (bubble). Bubbles are legal and do not advance the counter.
  - On the accept with counter == PAYLOAD_WORDS-1: tx_eof <= 1, o_pkt_cnt_g increments, go to GAP.
- GAP: tx_valid = 0 for GAP_CYCLES cycles, then IDLE.
- tx_afull is ignored once HEADER has been entered; every started packet runs to completion.
- Counter width: $clog2(PAYLOAD_WORDS). Gap counter width: $clog2(GAP_CYCLES+1).
- Requests that drop during a packet have no effect until the next IDLE evaluation.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - seq = 0; word and gap counters 0; both packet counters 0.
  - last_grant = 1, so channel 0 wins the first tie.
- Reset mid-packet: the next edge returns to IDLE with tx_valid, tx_eof and o_ready low. The partial packet is truncated with no eof; the downstream core discards it.
- o_ready is combinational from state and grant. All tx_* outputs are registered.
- Latency:
  - An accepted word appears on tx_data exactly 1 cycle later.
  - Header appears on tx_valid 2 cycles after the IDLE cycle in which the grant was made.
- Minimum packet period, with no bubbles and a request already pending: 1 (IDLE) + 1 (HEADER) + PAYLOAD_WORDS + GAP_CYCLES cycles.
- ce=0: the FSM, counters and tx_* registers hold, and o_ready0/1 are forced to 0. tx_valid is gated low so no word is duplicated.
- A seq wrap from 2^SEQ_WIDTH-1 to 0 requires no special handling.

## Test plan
- Single channel: PAYLOAD_WORDS=4, GAP_CYCLES=2, i_req0=1, i_data0 = 1,2,3,4 with no bubbles.
  - Header word 0x0000_0000_0000_0000, then 1,2,3,4 with tx_eof on the word 4 only.
  - 2 gap cycles; o_pkt_cnt0=1; next header seq=1.
- Both requests held high:
  - Packets alternate ch0, ch1, ch0.
  - Header bit 56 reads 0, 1, 0; seq reads 0, 1, 2.
  - o_ready1 is never high during a ch0 packet.
- Bubbles: i_valid0 toggled 1,0,1,0 during payload -> tx_valid shows the same gaps, exactly 4 payload words, eof on the 4th.
- tx_afull=1 while requests pending:
  - No header is issued.
  - If tx_afull rises mid-payload, the packet still completes with eof.
  - After tx_afull falls, the header appears 2 cycles later.
- Reset asserted on payload word 2 -> all outputs 0 next cycle, seq=0. The following tie grants ch0 first.
- SEQ_WIDTH=4 with 17 packets -> seq runs 15 then wraps to 0; o_pkt_cnt0 + o_pkt_cnt1 = 17.
